fb_nibble_responder: RTL
========================

FB_NIBBLE_RESPONDER -- requirements
Module: fb_nibble_responder

Interface
REQ-001 Parameter DEPTH, default 153600, number of 4-bit pixel entries (320 x 480).
REQ-002 Parameter ADDR_W, default $clog2(DEPTH), pointer width.
REQ-003 Parameter TURN_CYCLES, default 2, bus turnaround wait in cycles, legal range 1..15.
REQ-004 clk  input  1  single clock; all bus signals are synchronous to it.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 bus_in  input  8  initiator lines: [7] write_mode, [6] reset_ptr, [5] strobe, [4] unused, [3:0] write nibble.
REQ-007 bus_out  output  8  [3:0] read nibble, [7:4] constant 0.
REQ-008 bus_oe  output  8  1 = responder drives the bit; [7:4] constant 0.
REQ-009 ptr  output  ADDR_W  current shared read/write pointer.
REQ-010 in_write  output  1  high while in state WRITE.
REQ-011 wr_ack  output  1  one-cycle pulse per accepted write.
REQ-012 dbg_addr  input  ADDR_W  debug read address.
REQ-013 dbg_data  output  4  combinational mem[dbg_addr].

Function
REQ-014 States: READ, TURN_W, WRITE, TURN_R; bus_oe[3:0] = 4'hF only in READ, else 0.
REQ-015 READ: write_mode sampled high -> TURN_W at the same edge, counter cleared.
REQ-016 TURN_W: after TURN_CYCLES cycles -> WRITE; write_mode low during TURN_W -> TURN_R.
REQ-017 WRITE: write_mode sampled low -> TURN_R; TURN_R lasts exactly 1 cycle, then READ.
REQ-018 Strobes sampled in TURN_W or TURN_R are ignored: no pointer or memory change.
REQ-019 reset_ptr sampled high in any state: ptr <= 0 and any strobe in that cycle is ignored.
REQ-020 Read: strobe sampled high in READ at edge N -> bus_out[3:0] = mem[ptr] and ptr = ptr+1 after edge N; bus_out then holds until the next read.
REQ-021 Write: strobe sampled high in WRITE at edge N -> mem[ptr] = bus_in[3:0], ptr = ptr+1, wr_ack = 1 for the cycle after edge N.
REQ-022 Pointer wraps from DEPTH-1 to 0 in both modes; no flag is raised.
REQ-023 Strobe held high for k cycles = k operations, one per cycle, no back-pressure.
REQ-024 A mode change and a strobe in the same cycle: the mode change wins and the strobe is ignored.
REQ-025 Memory contents are not initialised or cleared by reset.

Reset
REQ-026 rst_n low: state = TURN_R, ptr = 0, bus_out = 0, bus_oe = 0, wr_ack = 0, in_write = 0, turnaround counter = 0.
REQ-027 Reset mid-write: writes already accepted persist; the strobe at the reset edge has no effect.
REQ-028 After release: first cycle in TURN_R, then READ with bus_oe[3:0] = 4'hF.

Structure
REQ-029 Shared package fb_bus_pkg holds the bus bit positions (WMODE = 7, RSTPTR = 6, STROBE = 5, DATA = 3:0) and the state encoding.
REQ-030 Storage is sub-module fb_nibble_ram: port A synchronous read/write, port B asynchronous read for debug.
REQ-031 The control FSM, turnaround counter and pointer live in fb_nibble_responder.

Verification (DEPTH = 16 on the bench)
REQ-032 Write mode, 3 strobes with data 4'h3, 4'hA, 4'hF after TURN_CYCLES -> dbg_data at addresses 0, 1, 2 = 3, A, F; ptr = 3; exactly 3 wr_ack pulses.
REQ-033 From that state: write_mode low, reset_ptr pulse, 3 read strobes -> bus_out[3:0] = 3, A, F, each valid the cycle after its strobe; bus_oe = 8'h0F.
REQ-034 16 writes then 1 more with data 4'h5 -> ptr wraps, mem[0] = 5, ptr = 1.
REQ-035 Strobe asserted together with write_mode rise, and during TURN_W -> no memory or ptr change; bus_oe = 0 in the same cycle as the rise is sampled.
REQ-036 rst_n asserted mid-burst asynchronously -> bus_oe = 0, ptr = 0 immediately; earlier writes still readable via dbg_addr.

Source files
------------

// File: rtl/fb_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_bus_pkg
// Purpose  : Shared bus bit positions, state encoding and constants for the
//            nibble frame-buffer responder.
// Revision : 1.0 - initial release
// ============================================================================
package fb_bus_pkg;

    // Initiator bus bit positions
    localparam int WMODE    = 7;
    localparam int RSTPTR   = 6;
    localparam int STROBE   = 5;
    localparam int DATA_MSB = 3;
    localparam int DATA_LSB = 0;

    // Responder drives the low nibble only while reading
    localparam logic [3:0] OE_DRIVE = 4'hF;
    localparam logic [3:0] OE_FLOAT = 4'h0;

    // Control FSM encoding
    typedef enum logic [1:0] {
        ST_READ   = 2'd0,
        ST_TURN_W = 2'd1,
        ST_WRITE  = 2'd2,
        ST_TURN_R = 2'd3
    } fb_state_e;

endpackage : fb_bus_pkg
`default_nettype wire

// File: rtl/fb_nibble_ram.sv
`default_nettype none
// ============================================================================
// Module   : fb_nibble_ram
// Purpose  : 4-bit wide storage. Port A: synchronous read/write sharing one
//            address; the read register holds until the next read. Port B:
//            asynchronous read used for debug visibility.
// Revision : 1.0 - initial release
// ============================================================================
module fb_nibble_ram
    import fb_bus_pkg::*;
#(
    parameter int DEPTH  = 153600,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic              a_we,
    input  logic              a_re,
    input  logic [3:0]        a_wdata,
    output logic [3:0]        a_rdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [3:0]        b_rdata
);

    // Array contents are deliberately left out of reset
    logic [3:0] mem [DEPTH];

    logic [3:0] rdata_d;
    logic [3:0] rdata_q;

    // Write port: store the nibble on an accepted write
    always_ff @(posedge clk) begin
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    // Read data next-value: load on a read, otherwise hold the last value
    always_comb begin
        rdata_d = rdata_q;
        if (a_re) begin
            rdata_d = mem[a_addr];
        end
    end

    // Read data register, cleared by reset so the bus idles at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= 4'h0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign a_rdata = rdata_q;
    assign b_rdata = mem[b_addr];

endmodule : fb_nibble_ram
`default_nettype wire

// File: rtl/fb_nibble_responder.sv
`default_nettype none
// ============================================================================
// Module   : fb_nibble_responder
// Purpose  : Bidirectional nibble bus responder in front of a frame buffer.
//            A turnaround FSM switches between READ and WRITE; a shared
//            auto-incrementing pointer addresses the storage in both modes.
// Revision : 1.0 - initial release
// ============================================================================
module fb_nibble_responder
    import fb_bus_pkg::*;
#(
    parameter int DEPTH       = 153600,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int TURN_CYCLES = 2            // legal range 1..15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        bus_in,
    output logic [7:0]        bus_out,
    output logic [7:0]        bus_oe,
    output logic [ADDR_W-1:0] ptr,
    output logic              in_write,
    output logic              wr_ack,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [3:0]        dbg_data
);

    localparam logic [3:0]        TURN_LAST = 4'(TURN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);

    // Decoded initiator lines
    logic       w_wmode;
    logic       w_rstptr;
    logic       w_strobe;
    logic [3:0] w_wdata;
    logic       unused_bus_bit;

    assign w_wmode        = bus_in[WMODE];
    assign w_rstptr       = bus_in[RSTPTR];
    assign w_strobe       = bus_in[STROBE];
    assign w_wdata        = bus_in[DATA_MSB:DATA_LSB];
    assign unused_bus_bit = bus_in[4];

    // Registered state and their next values
    fb_state_e         state_d,    state_q;
    logic [3:0]        cnt_d,      cnt_q;
    logic [ADDR_W-1:0] ptr_d,      ptr_q;
    logic [3:0]        oe_d,       oe_q;
    logic              in_write_d, in_write_q;
    logic              wr_ack_d,   wr_ack_q;

    // Storage port A controls
    logic              ram_we;
    logic              ram_re;
    logic [3:0]        ram_rdata;

    // Pointer increment with wrap at the last entry
    logic [ADDR_W-1:0] w_ptr_inc;
    logic              w_op;

    assign w_ptr_inc = (ptr_q == PTR_LAST) ? '0 : ptr_q + ADDR_W'(1);

    // A strobe only counts when the pointer is not being reset the same cycle
    assign w_op = w_strobe && !w_rstptr;

    // Next-state, pointer and access decode; mode changes take priority over strobes
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        wr_ack_d = 1'b0;
        ram_we   = 1'b0;
        ram_re   = 1'b0;

        case (state_q)
            ST_READ: begin
                if (w_wmode) begin
                    state_d = ST_TURN_W;
                    cnt_d   = 4'd0;
                end else if (w_op) begin
                    ram_re = 1'b1;
                    ptr_d  = w_ptr_inc;
                end
            end
            ST_TURN_W: begin
                // Strobes are ignored while the bus turns around
                if (!w_wmode) begin
                    state_d = ST_TURN_R;
                    cnt_d   = 4'd0;
                end else if (cnt_q == TURN_LAST) begin
                    state_d = ST_WRITE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_WRITE: begin
                if (!w_wmode) begin
                    state_d = ST_TURN_R;
                end else if (w_op) begin
                    ram_we   = 1'b1;
                    ptr_d    = w_ptr_inc;
                    wr_ack_d = 1'b1;
                end
            end
            ST_TURN_R: begin
                // Single-cycle turnaround back to the driving direction
                state_d = ST_READ;
            end
            default: begin
                state_d = ST_TURN_R;
            end
        endcase

        if (w_rstptr) begin
            ptr_d = '0;
        end

        // Outputs are registered from the next state so they align with it
        oe_d       = (state_d == ST_READ) ? OE_DRIVE : OE_FLOAT;
        in_write_d = (state_d == ST_WRITE);
    end

    // Control registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_TURN_R;
            cnt_q      <= 4'd0;
            ptr_q      <= '0;
            oe_q       <= OE_FLOAT;
            in_write_q <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            oe_q       <= oe_d;
            in_write_q <= in_write_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    fb_nibble_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_addr  (ptr_q),
        .a_we    (ram_we),
        .a_re    (ram_re),
        .a_wdata (w_wdata),
        .a_rdata (ram_rdata),
        .b_addr  (dbg_addr),
        .b_rdata (dbg_data)
    );

    assign bus_out  = {4'h0, ram_rdata};
    assign bus_oe   = {4'h0, oe_q};
    assign ptr      = ptr_q;
    assign in_write = in_write_q;
    assign wr_ack   = wr_ack_q;

endmodule : fb_nibble_responder
`default_nettype wire
